seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Multiplexed N-digit seven-segment display driver with integrated scan timing, replacing the external next_segment strobe with an internal prescaler. Per-slot PWM brightness, per-digit blink and configurable drive polarity. Sits between the digit-value producers (counters, debug registers) and the Pmod LED pins; one instance drives one display module.

Parameters:
NUMBER_OF_DIGITS, 6, digits scanned per frame (>=1).
CATHODE_COMMON, 1'b0, drive polarity: 1 = segments active-high and selectors active-low; 0 = segments active-low and selectors active-high.
PRESCALE, 1000, clock cycles per PWM sub-step (>=1).
BRIGHTNESS_BITS, 4, brightness width B; each digit slot has 2^B sub-steps.
BLINK_FRAMES, 64, frames per blink half-period (>=1).

Ports:
clock  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
digits  input  6 x NUMBER_OF_DIGITS (unpacked [0:N-1])  per digit: [5] enable, [4] decimal point, [3:0] hex value.
blink_mask  input  NUMBER_OF_DIGITS  bit i=1: digit i blinks.
brightness  input  BRIGHTNESS_BITS  lit sub-steps per slot (0 = dark).
segment_out  output  8  {dp,g,f,e,d,c,b,a}, polarity per CATHODE_COMMON.
digit_selector_out  output  NUMBER_OF_DIGITS  one-hot active digit, polarity per CATHODE_COMMON.
frame_done  output  1  one-cycle pulse per completed frame.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Counters: pre (0..PRESCALE-1), step (0..2^B-1, increments when pre wraps), index (0..N-1, increments when step wraps; N-1 wraps to 0), blink_cnt (0..BLINK_FRAMES-1, increments on index wrap), blink_phase (toggles when blink_cnt wraps).
- Slot length = PRESCALE*2^B cycles; frame length = N*slot.
- Slot start: the cycle with pre==0 and step==0, including the first cycle after reset release. At slot start, latch the decoded pattern of digits[index], digits[index][5], blink_mask[index] and brightness. Input changes mid-slot are ignored until the next slot start, so there is no tearing.
- Decode: 0..F uses the standard hex patterns (0 = 0x3F, 1 = 0x06, 8 = 0x7F, A = 0x77, F = 0x71). Bit 7 = dp.
- Lit condition, all from latched values: enable && step<brightness && !(blink && blink_phase).
  - Lit: segment_out = pattern and digit_selector_out = one-hot(index), both in active polarity.
  - Otherwise: all segments and all selectors inactive. The selector is never active with blank segments.
- Outputs are registered and lag the internal counters by exactly 1 cycle.
- Maximum brightness 2^B-1 gives a (2^B-1)/2^B duty cycle. The dark sub-step is intentional anti-ghosting dead time at the digit change.
- frame_done: registered, asserted in the output cycle where digit 0's slot begins after a wrap from N-1. It is not asserted for the first frame after reset. It pulses regardless of brightness or enable.
- Reset values:
  - segment_out: all inactive (0x00 if CATHODE_COMMON=1, 0xFF if 0).
  - digit_selector_out: all inactive.
  - frame_done: 0.
  - All counters and blink_phase: 0.
  - Latches: blank.
- Reset mid-frame: outputs inactive on the next cycle, then scanning restarts at digit 0 with blink_phase 0.
- N=1: index is constant 0 and frame = slot. PRESCALE=1: step advances every cycle.

Decomposition:
- Package seven_segment_pkg: digit_t packed struct {enable, dp, value[3:0]}; segment pattern constants for 0..F; localparam NUMBER_OF_SEGMENTS=8.
- Sub-module seven_segment_decoder: combinational, 4-bit value plus dp to 8-bit active-high pattern. The scanner applies polarity.

Test Plan:
All scenarios use N=4, PRESCALE=2, B=2 (slot 8 cycles, frame 32 cycles) and CATHODE_COMMON=1 unless stated.
1. Hold reset -> segment_out=0x00, digit_selector_out=4'b1111, frame_done=0. Release -> first lit output 1 cycle later.
2. digits = {en,val} 0,1,2,3 with dp=0, brightness=3 -> slot 0: selector 4'b1110 and segment 0x3F for 6 cycles, then dark 2 cycles. Slot 1: 4'b1101 / 0x06. frame_done every 32 cycles from the second frame on.
3. brightness=0 -> outputs always inactive, frame_done still every 32 cycles. brightness changed mid-slot -> applies at the next slot start only.
4. Digit 2 with enable=0 -> slot 2 fully dark. Digit 3 = 8 with dp=1 -> 0xFF. CATHODE_COMMON=0 -> 0x00 with selector 4'b1000.
5. BLINK_FRAMES=2, blink_mask=4'b0010 -> digit 1 lit in frames 0-1, blank in frames 2-3, period 4 frames. Other digits unaffected.
6. Assert reset mid-slot of digit 2 for 1 cycle -> next cycle outputs inactive, scan restarts at digit 0, no frame_done pulse, blink_phase 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package seven_segment_pkg;

  localparam int NUMBER_OF_SEGMENTS = 8;

  typedef struct packed {
    logic       enable;
    logic       dp;
    logic [3:0] value;
  } digit_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Element [v] holds the pattern for hex value v.
  localparam logic [15:0][6:0] SEGMENT_PATTERNS = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex value plus decimal point to an active-high {dp,g,f,e,d,c,b,a} pattern.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0]                    value,
  input  logic                          dp,
  output logic [NUMBER_OF_SEGMENTS-1:0] pattern
);

  assign pattern = {dp, SEGMENT_PATTERNS[value]};

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment driver: internal scan prescaler, per-slot
// PWM brightness, per-digit blink and selectable drive polarity.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int   NUMBER_OF_DIGITS = 6,
  parameter logic CATHODE_COMMON   = 1'b0,
  parameter int   PRESCALE         = 1000,
  parameter int   BRIGHTNESS_BITS  = 4,
  parameter int   BLINK_FRAMES     = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  digit_t                        digits [0:NUMBER_OF_DIGITS-1],
  input  logic [NUMBER_OF_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHTNESS_BITS-1:0]    brightness,
  output logic [NUMBER_OF_SEGMENTS-1:0] segment_out,
  output logic [NUMBER_OF_DIGITS-1:0]   digit_selector_out,
  output logic                          frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Idle levels; XOR with these converts active-high to the drive polarity.
  localparam logic [NUMBER_OF_SEGMENTS-1:0] SEG_IDLE = {NUMBER_OF_SEGMENTS{~CATHODE_COMMON}};
  localparam logic [NUMBER_OF_DIGITS-1:0]   SEL_IDLE = {NUMBER_OF_DIGITS{CATHODE_COMMON}};

  logic [PW-1:0]              pre;
  logic [BRIGHTNESS_BITS-1:0] step;
  logic [IW-1:0]              index;
  logic [BW-1:0]              blink_cnt;
  logic                       blink_phase;
  logic                       frame_pending;

  logic [NUMBER_OF_SEGMENTS-1:0] lat_pattern;
  logic                          lat_enable;
  logic                          lat_blink;
  logic [BRIGHTNESS_BITS-1:0]    lat_brightness;

  logic pre_wrap, step_wrap, index_wrap, blink_wrap, slot_start;
  assign pre_wrap   = (pre == PW'(PRESCALE - 1));
  assign step_wrap  = pre_wrap && (step == '1);
  assign index_wrap = step_wrap && (index == IW'(NUMBER_OF_DIGITS - 1));
  assign blink_wrap = index_wrap && (blink_cnt == BW'(BLINK_FRAMES - 1));
  assign slot_start = (pre == '0) && (step == '0);

  digit_t                        live_digit;
  logic [NUMBER_OF_SEGMENTS-1:0] live_pattern;
  assign live_digit = digits[index];

  seven_segment_decoder u_decoder (
    .value   (live_digit.value),
    .dp      (live_digit.dp),
    .pattern (live_pattern)
  );

  // At slot start the freshly sampled inputs drive this cycle's output and
  // are captured; for the rest of the slot only the captured copy is used.
  logic [NUMBER_OF_SEGMENTS-1:0] eff_pattern;
  logic                          eff_enable;
  logic                          eff_blink;
  logic [BRIGHTNESS_BITS-1:0]    eff_brightness;
  logic                          lit;
  logic [NUMBER_OF_DIGITS-1:0]   one_hot;

  always_comb begin
    eff_pattern    = lat_pattern;
    eff_enable     = lat_enable;
    eff_blink      = lat_blink;
    eff_brightness = lat_brightness;
    if (slot_start) begin
      eff_pattern    = live_pattern;
      eff_enable     = live_digit.enable;
      eff_blink      = blink_mask[index];
      eff_brightness = brightness;
    end
    lit = eff_enable && (step < eff_brightness) && !(eff_blink && blink_phase);
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      one_hot[i] = (index == IW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre                <= '0;
      step               <= '0;
      index              <= '0;
      blink_cnt          <= '0;
      blink_phase        <= 1'b0;
      frame_pending      <= 1'b0;
      lat_pattern        <= '0;
      lat_enable         <= 1'b0;
      lat_blink          <= 1'b0;
      lat_brightness     <= '0;
      segment_out        <= SEG_IDLE;
      digit_selector_out <= SEL_IDLE;
      frame_done         <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) step <= step + BRIGHTNESS_BITS'(1);
      if (step_wrap) index <= (index == IW'(NUMBER_OF_DIGITS - 1)) ? '0 : index + IW'(1);
      if (index_wrap) blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) blink_phase <= ~blink_phase;

      lat_pattern    <= eff_pattern;
      lat_enable     <= eff_enable;
      lat_blink      <= eff_blink;
      lat_brightness <= eff_brightness;

      segment_out        <= lit ? (eff_pattern ^ SEG_IDLE) : SEG_IDLE;
      digit_selector_out <= lit ? (one_hot ^ SEL_IDLE) : SEL_IDLE;
      // Two-stage delay puts the pulse on the first output cycle of digit 0.
      frame_pending <= index_wrap;
      frame_done    <= frame_pending;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: both drive polarities share stimulus and
// are checked every cycle against a slot/frame arithmetic reference model.
module tb_seven_segment_scanner;
  import seven_segment_pkg::*;

  localparam int N         = 4;
  localparam int PRE       = 2;
  localparam int B         = 2;
  localparam int BLINK_FR  = 2;
  localparam int SLOT_LEN  = PRE * (1 << B);
  localparam int FRAME_LEN = N * SLOT_LEN;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  digit_t         digits [0:N-1];
  logic [N-1:0]   blink_mask;
  logic [B-1:0]   brightness;
  logic [7:0]     seg_cc1, seg_cc0;
  logic [N-1:0]   sel_cc1, sel_cc0;
  logic           fd_cc1, fd_cc0;

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS (N), .CATHODE_COMMON (1'b1), .PRESCALE (PRE),
    .BRIGHTNESS_BITS (B), .BLINK_FRAMES (BLINK_FR)
  ) dut_cc1 (
    .clock (clock), .reset (reset), .digits (digits), .blink_mask (blink_mask),
    .brightness (brightness), .segment_out (seg_cc1),
    .digit_selector_out (sel_cc1), .frame_done (fd_cc1)
  );

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS (N), .CATHODE_COMMON (1'b0), .PRESCALE (PRE),
    .BRIGHTNESS_BITS (B), .BLINK_FRAMES (BLINK_FR)
  ) dut_cc0 (
    .clock (clock), .reset (reset), .digits (digits), .blink_mask (blink_mask),
    .brightness (brightness), .segment_out (seg_cc0),
    .digit_selector_out (sel_cc0), .frame_done (fd_cc0)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: cycle k counted from reset release
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         k;
  logic       m_en, m_blink;
  logic [7:0] m_pat;
  int         m_bright;

  task automatic run_cycle();
    int         idx, stp, phase;
    logic       lit;
    logic [7:0] exp_seg;
    logic [7:0] exp_sel;
    logic       exp_fd;
    idx   = (k / SLOT_LEN) % N;
    stp   = (k % SLOT_LEN) / PRE;
    phase = ((k / FRAME_LEN) / BLINK_FR) % 2;
    if (k % SLOT_LEN == 0) begin
      m_en     = digits[idx].enable;
      m_pat    = {digits[idx].dp, hex_tab[digits[idx].value]};
      m_blink  = blink_mask[idx];
      m_bright = int'(brightness);
    end
    lit     = m_en && (stp < m_bright) && !(m_blink && phase == 1);
    exp_seg = lit ? m_pat : 8'h00;
    exp_sel = lit ? (8'd1 << idx) : 8'h00;
    exp_fd  = (k % FRAME_LEN == 0) && (k >= FRAME_LEN);
    @(posedge clock);
    #1;
    check("seg_cc1", seg_cc1, exp_seg);
    check("sel_cc1", {4'h0, sel_cc1}, {4'h0, ~exp_sel[N-1:0]});
    check("seg_cc0", seg_cc0, ~exp_seg);
    check("sel_cc0", {4'h0, sel_cc0}, exp_sel);
    check("fd_cc1", {7'h0, fd_cc1}, {7'h0, exp_fd});
    check("fd_cc0", {7'h0, fd_cc0}, {7'h0, exp_fd});
    k++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // one reset cycle; outputs must be idle right after it
  task automatic reset_cycle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_seg_cc1", seg_cc1, 8'h00);
    check("rst_sel_cc1", {4'h0, sel_cc1}, 8'h0F);
    check("rst_seg_cc0", seg_cc0, 8'hFF);
    check("rst_sel_cc0", {4'h0, sel_cc0}, 8'h00);
    check("rst_fd", {6'h0, fd_cc1, fd_cc0}, 8'h00);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic set_digit(input int i, input logic en, input logic dp, input logic [3:0] v);
    digits[i] = '{enable: en, dp: dp, value: v};
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_digit(i, 1'b1, 1'b0, 4'(i));
    blink_mask = '0;
    brightness = 2'd3;
    k = 0;

    // reset held, then release: scan of digits 0..3 for two frames
    reset_cycle();
    reset = 1'b1;
    reset_cycle();
    reset_cycle();
    run_cycles(2 * FRAME_LEN + 1);

    // dark brightness, frame_done keeps pulsing
    brightness = 2'd0;
    run_cycles(FRAME_LEN + 3);
    // change mid-slot: takes effect at next slot start only
    brightness = 2'd1;
    run_cycles(FRAME_LEN);
    brightness = 2'd2;
    run_cycles(3);
    brightness = 2'd3;
    run_cycles(FRAME_LEN);

    // disabled digit 2, digit 3 = 8 with dp, plus some hex letters
    set_digit(2, 1'b0, 1'b0, 4'h5);
    set_digit(3, 1'b1, 1'b1, 4'h8);
    set_digit(0, 1'b1, 1'b0, 4'hA);
    set_digit(1, 1'b1, 1'b1, 4'hF);
    run_cycles(FRAME_LEN);

    // blink digit 1 across two full blink periods
    blink_mask = 4'b0010;
    run_cycles(4 * FRAME_LEN * 2);

    // reset mid-slot of digit 2, then scanning restarts at digit 0
    while ((k % FRAME_LEN) != 2 * SLOT_LEN + 3) run_cycle();
    reset_cycle();
    run_cycles(2 * FRAME_LEN);

    // randomized inputs changing at random times
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        digits[$urandom_range(0, N - 1)] = digit_t'(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 40) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 250) == 0) reset_cycle();
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
